// File: rtl/dds_phase_addr_gen.sv
// DDS phase accumulator driving the sin/cos ROM address, with phase-continuous
// (wrap-aligned) tuning-word updates and a data_valid that tracks ROM latency.
module dds_phase_addr_gen #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 11,
  parameter int ROM_LAT = 2
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              enable,
  input  logic [ACC_W-1:0]  tune_word,
  input  logic              tune_load,
  input  logic [ADDR_W-1:0] phase_offset,
  input  logic              sync_clr,
  output logic [ADDR_W-1:0] Address,
  output logic              addr_valid,
  output logic              data_valid,
  output logic              wrap,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam int CNT_W = $clog2(ROM_LAT + 1);

  logic [1:0]       state;
  logic [ACC_W-1:0] acc, active_tw, pend_tw, sum;
  logic             pend_flag, carry, step, wrap_now;
  logic [CNT_W-1:0] drain_cnt;
  // [0] is addr_valid, [ROM_LAT] is the same sample as the ROM data emerges
  logic [ROM_LAT:0] vld_pipe;

  assign {carry, sum} = {1'b0, acc} + {1'b0, active_tw};
  assign step         = (state == S_RUN) && enable;
  assign wrap_now     = step && carry && !sync_clr;

  assign addr_valid = vld_pipe[0];
  assign data_valid = vld_pipe[ROM_LAT];
  assign busy       = (state != S_IDLE);

  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      state     <= S_IDLE;
      acc       <= '0;
      active_tw <= '0;
      pend_tw   <= '0;
      pend_flag <= 1'b0;
      drain_cnt <= '0;
      Address   <= '0;
      vld_pipe  <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap     <= wrap_now;
      vld_pipe <= {vld_pipe[ROM_LAT-1:0], step};

      // Address uses the pre-increment accumulator
      if (step) Address <= acc[ACC_W-1 -: ADDR_W] + phase_offset;

      if (sync_clr)  acc <= '0;
      else if (step) acc <= sum;

      case (state)
        S_IDLE:  if (enable) state <= S_RUN;
        S_RUN:   if (!enable) begin
                   state     <= S_DRAIN;
                   drain_cnt <= '0;
                 end
        S_DRAIN: if (enable) begin
                   state     <= S_RUN;
                   drain_cnt <= '0;
                 end else if (drain_cnt == CNT_W'(ROM_LAT - 1)) begin
                   state     <= S_IDLE;
                   drain_cnt <= '0;
                 end else begin
                   drain_cnt <= drain_cnt + CNT_W'(1);
                 end
        default: state <= S_IDLE;
      endcase

      // While running, new words wait for the next carry to keep phase continuous
      if (state != S_RUN) begin
        if (tune_load) begin
          active_tw <= tune_word;
          pend_flag <= 1'b0;
        end
      end else if (tune_load && wrap_now) begin
        active_tw <= tune_word;
        pend_flag <= 1'b0;
      end else if (tune_load) begin
        pend_tw   <= tune_word;
        pend_flag <= 1'b1;
      end else if (wrap_now && pend_flag) begin
        active_tw <= pend_tw;
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_addr_gen.sv
// Randomized + directed bench for dds_phase_addr_gen against a behavioural
// model of the phase accumulator, tuning and valid timing.
module tb_dds_phase_addr_gen;
  localparam int ACC_W   = 32;
  localparam int ADDR_W  = 11;
  localparam int ROM_LAT = 2;
  localparam longint MOD = 64'h1_0000_0000;

  logic              Fg_CLK = 1'b0;
  logic              RESETn = 1'b0;
  logic              enable = 1'b0;
  logic [ACC_W-1:0]  tune_word = '0;
  logic              tune_load = 1'b0;
  logic [ADDR_W-1:0] phase_offset = '0;
  logic              sync_clr = 1'b0;
  logic [ADDR_W-1:0] Address;
  logic              addr_valid, data_valid, wrap, busy;

  int n_cmp = 0;
  int n_err = 0;

  // model: mode 0=idle 1=run 2=drain
  int     m_mode = 0;
  longint m_acc = 0, m_tw = 0, m_ptw = 0;
  bit     m_pf = 0;
  int     m_left = 0;
  int     m_addr = 0;
  bit     m_av = 0, m_wrap = 0;
  bit     av_hist[$];

  dds_phase_addr_gen #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT)) dut (
    .Fg_CLK(Fg_CLK), .RESETn(RESETn), .enable(enable), .tune_word(tune_word),
    .tune_load(tune_load), .phase_offset(phase_offset), .sync_clr(sync_clr),
    .Address(Address), .addr_valid(addr_valid), .data_valid(data_valid),
    .wrap(wrap), .busy(busy)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    longint s;
    bit     c;
    if (!RESETn) begin
      m_mode = 0; m_acc = 0; m_tw = 0; m_ptw = 0; m_pf = 0; m_left = 0;
      m_addr = 0; m_av = 0; m_wrap = 0;
      av_hist = '{0, 0, 0};
      return;
    end
    m_av = 0; m_wrap = 0;
    case (m_mode)
      0: begin
        if (tune_load) begin m_tw = tune_word; m_pf = 0; end
        if (enable) m_mode = 1;
      end
      1: begin
        if (enable) begin
          m_addr = (int'(m_acc >> (ACC_W - ADDR_W)) + int'(phase_offset)) % (1 << ADDR_W);
          m_av   = 1;
          s      = m_acc + m_tw;
          c      = (s >= MOD) && !sync_clr;
          m_acc  = s % MOD;
          m_wrap = c;
          if (tune_load && c) begin m_tw = tune_word; m_pf = 0; end
          else if (tune_load) begin m_ptw = tune_word; m_pf = 1; end
          else if (c && m_pf) begin m_tw = m_ptw; m_pf = 0; end
        end else begin
          m_mode = 2; m_left = ROM_LAT;
          if (tune_load) begin m_ptw = tune_word; m_pf = 1; end
        end
      end
      default: begin
        if (tune_load) begin m_tw = tune_word; m_pf = 0; end
        if (enable) m_mode = 1;
        else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
    endcase
    if (sync_clr) m_acc = 0;
  endtask

  task automatic cyc();
    @(posedge Fg_CLK);
    model_step();
    av_hist.push_back(m_av);
    if (av_hist.size() > 8) void'(av_hist.pop_front());
    #1;
    chk("address",    32'(Address),    32'(m_addr));
    chk("addr_valid", 32'(addr_valid), 32'(m_av));
    chk("data_valid", 32'(data_valid), 32'(av_hist[av_hist.size() - 1 - ROM_LAT]));
    chk("wrap",       32'(wrap),       32'(m_wrap));
    chk("busy",       32'(busy),       32'(m_mode != 0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load(input logic [31:0] w);
    tune_word = w; tune_load = 1'b1;
    cyc();
    tune_load = 1'b0;
  endtask

  task automatic run_until_acc(input longint target, input int bound);
    int k = 0;
    while (m_acc != target && k < bound) begin cyc(); k++; end
    if (k >= bound) chk("acc_reach_timeout", 32'(k), 32'(0));
  endtask

  initial begin
    int wc;
    // reset state
    run(2);
    RESETn = 1'b1;
    run(2);

    // basic sweep, exactly one wrap in any 2048 consecutive steps
    load(32'h0020_0000);
    enable = 1'b1;
    wc = 0;
    for (int i = 0; i < 2100; i++) begin
      cyc();
      if (i >= 10 && i < 2058) wc += int'(wrap);
    end
    chk("wrap_per_2048", 32'(wc), 32'(1));

    // drain, resume mid-drain, then full drain to idle
    enable = 1'b0; cyc();
    enable = 1'b1; run(6);
    enable = 1'b0; run(5);

    // phase offset from a fresh reset
    RESETn = 1'b0; cyc(); RESETn = 1'b1;
    phase_offset = 11'd1024;
    load(32'h0020_0000);
    enable = 1'b1;
    run(1100);

    // deferred tuning, then a load coinciding with the carry
    run_until_acc(64'h4000_0000, 5000);
    load(32'h0040_0000);
    run(1600);
    run_until_acc(64'hFFC0_0000, 5000);
    load(32'h0010_0000);
    run(50);

    // sync_clr mid-run
    run_until_acc(64'hC000_0000, 5000);
    sync_clr = 1'b1; cyc(); sync_clr = 1'b0;
    run(20);

    // reset with a pending word: runs frozen on tune word 0 afterwards
    load(32'h0123_4567);
    cyc();
    RESETn = 1'b0; cyc(); RESETn = 1'b1;
    run(20);
    enable = 1'b0; run(4);
    load(32'h0080_0000);
    enable = 1'b1; run(40);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(49) == 0) enable = ~enable;
      tune_load = ($urandom_range(79) == 0);
      case ($urandom_range(2))
        0: tune_word = $urandom();
        1: tune_word = 32'($urandom_range(8)) << 21;
        default: tune_word = 32'h0100_0000 + (32'($urandom_range(255)) << 12);
      endcase
      sync_clr = ($urandom_range(299) == 0);
      if ($urandom_range(399) == 0) phase_offset = 11'($urandom());
      RESETn = ($urandom_range(1499) != 0);
      cyc();
    end
    RESETn = 1'b1; tune_load = 1'b0; sync_clr = 1'b0; enable = 1'b0;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dds_phase_addr_gen.md
Name: dds_phase_addr_gen

Overview:
- DDS phase accumulator that produces the 11-bit `Address` stream for the sin/cos coefficient ROM lookup.
- The ROM is the responder; this block is the initiator.
- Generates `data_valid`, which tracks the ROM's registered read latency, so downstream logic knows when `sin1x`/`cos2x` are meaningful.
- Tuning-word changes are double-buffered and applied only at a phase wrap, so frequency changes are phase-continuous.

Parameters:
- ACC_W, 32, accumulator width in bits.
- ADDR_W, 11, ROM address width; the address is taken from the top ADDR_W bits of the accumulator.
- ROM_LAT, 2, clock cycles from `Address` registered to ROM data valid.

Ports:
- Fg_CLK  in  1  system clock; all logic on the rising edge.
- RESETn  in  1  synchronous, active-low reset.
- enable  in  1  run request.
- tune_word  in  ACC_W  frequency tuning word.
- tune_load  in  1  one-cycle strobe; captures `tune_word`.
- phase_offset  in  ADDR_W  static phase offset added to the address.
- sync_clr  in  1  one-cycle strobe; zeroes the accumulator.
- Address  out  ADDR_W  registered ROM address.
- addr_valid  out  1  `Address` is a live sample this cycle.
- data_valid  out  1  ROM output corresponds to a valid address.
- wrap  out  1  one-cycle pulse on accumulator carry-out.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: in any cycle with RESETn=0, all of the following are cleared:
  - acc, active_tw, pend_tw, pend_flag, drain counter all 0;
  - Address=0, addr_valid=0, data_valid pipeline=0, wrap=0, busy=0;
  - state=IDLE.
  - Reset mid-operation aborts everything immediately, with no drain.
- States:
  - IDLE: accumulator holds; addr_valid=0; Address holds its last value.
  - RUN:
    - acc <= acc + active_tw, modulo 2^ACC_W.
    - wrap <= carry-out of that add.
    - Address <= acc[ACC_W-1 -: ADDR_W] + phase_offset, modulo 2^ADDR_W; this uses the pre-increment acc.
    - addr_valid <= 1.
  - DRAIN: accumulator holds; addr_valid=0; counter runs for ROM_LAT cycles.
- Transitions:
  - IDLE->RUN when enable=1; addr_valid first goes high in the cycle after entry.
  - RUN->DRAIN when enable=0.
  - DRAIN->RUN when enable=1; the accumulator resumes without reset.
  - DRAIN->IDLE when the counter reaches ROM_LAT with enable=0.
- busy=1 in RUN and DRAIN.
- data_valid: addr_valid delayed by exactly ROM_LAT cycles through a shift register.
- Tuning:
  - tune_load in IDLE or DRAIN: active_tw <= tune_word directly; pend_flag stays 0.
  - tune_load in RUN: pend_tw <= tune_word, pend_flag <= 1. A later load before the wrap overwrites pend_tw (last load wins).
  - In RUN, on the cycle the add carries out with pend_flag=1: active_tw <= pend_tw, pend_flag <= 0. The new word takes effect on the next add.
  - tune_load coinciding with a carry cycle: tune_word is applied directly, and pend_flag is cleared.
  - active_tw=0 in RUN: accumulator frozen, addr_valid stays 1, no wrap.
- sync_clr:
  - acc <= 0 next cycle in any state; overrides the increment.
  - wrap is not asserted for that cycle.
  - active_tw, pend_tw and the valid pipeline are unaffected.
- wrap is 0 outside RUN.

Test Plan:
- Basic sweep: reset, tune_load with tune_word=0x0020_0000, enable=1 held.
  -> Address runs 0,1,2,…,2047,0; addr_valid=1 from the 2nd cycle after enable.
  -> wrap pulses once per 2048 cycles; data_valid rises exactly 2 cycles after addr_valid.
- Phase offset: phase_offset=1024, tune_word=0x0020_0000.
  -> first valid Address=1024; after 1024 samples Address reaches 0 (modulo wrap).
  -> wrap still aligns to the accumulator carry, not to the Address.
- Deferred tuning: running at 0x0020_0000, tune_load 0x0040_0000 at acc=0x4000_0000.
  -> step stays 1 per cycle until the carry cycle, then becomes 2 per cycle; pend_flag clears.
  -> Second case: a load coinciding with the carry applies immediately.
- Drain and resume:
  -> drop enable: addr_valid=0 the next cycle; data_valid falls 2 cycles later; busy falls after the 2-cycle DRAIN.
  -> re-raise enable during DRAIN: RUN resumes from the held acc value, with no address discontinuity.
- sync_clr: assert mid-run at acc=0xC000_0000.
  -> acc=0 next cycle; Address=0+phase_offset the following cycle; no wrap pulse.
  -> tuning word unchanged.
- Reset mid-run: RESETn=0 for 1 cycle while RUN with pend_flag=1.
  -> all outputs 0, state IDLE, pending word discarded.
  -> enable afterwards runs with tune_word 0 until a new load.
